// File: rtl/rf_pkg.sv
// rf_pkg: shared types and helpers for the multi-port register file.
//   vtx_state_t : vertex burst FSM states
//   in_vtx()    : true when a register index lies in the vertex window
package rf_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } vtx_state_t;

    function automatic logic in_vtx(input int addr, input int base = 8, input int count = 8);
        return (addr >= base) && (addr < base + count);
    endfunction

endpackage

// File: rtl/vtx_burst_ctrl.sv
// vtx_burst_ctrl: beat-based VPU vertex burst controller.
//   clk, rst_n          : clock, async active-low reset
//   vtx_hold            : CPU blocks the start of a new burst (ignored mid-burst)
//   vtx_valid/vtx_ready : beat handshake
//   vtx_done            : one-cycle pulse after the last beat is written
//   busy                : a burst is in progress
//   grp_we              : one-hot lane-group write enable for the accepted beat
module vtx_burst_ctrl
    import rf_pkg::*;
#(
    parameter int BEATS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vtx_hold,
    input  logic             vtx_valid,
    output logic             vtx_ready,
    output logic             vtx_done,
    output logic             busy,
    output logic [BEATS-1:0] grp_we
);

    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

    vtx_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          accept;

    assign vtx_ready = (state_q == BURST) || !vtx_hold;
    assign accept    = vtx_valid && vtx_ready;
    assign busy      = (state_q == BURST);
    assign vtx_done  = done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (accept) begin
            if (state_q == IDLE && BEATS > 1) begin
                state_d = BURST;
                cnt_d   = CW'(1);
            end else if (state_q == IDLE || cnt_q == CW'(BEATS - 1)) begin
                state_d = IDLE;
                cnt_d   = '0;
                done_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        // counter is 0 in IDLE, so the first beat always targets group 0
        for (int g = 0; g < BEATS; g++) begin
            grp_we[g] = accept && (cnt_q == CW'(g));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// register_file_mp: parametrised multi-port register file for the CPU/VPU pair.
//   rd_addr/rd_data/rd_busy : combinational read ports with write-first forwarding
//   wr_en/wr_addr/wr_data   : CPU write ports, highest index wins on collision
//   flags_we/flags_in       : flags write, beats CPU ports at FLAG_IDX
//   ro_we/ro_in             : return-object write (only writer of RO_IDX)
//   vtx_*                   : VPU vertex burst interface and parallel vertex view
//   wr_conflict             : a write was overridden or dropped last cycle
//   flags_out/ro_out        : flags and return-object register contents
module register_file_mp
    import rf_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int NUM_REGS  = 32,
    parameter int RD_PORTS  = 2,
    parameter int WR_PORTS  = 2,
    parameter int VTX_BASE  = 8,
    parameter int VTX_COUNT = 8,
    parameter int VTX_LANES = 4,
    parameter int FLAG_IDX  = 22,
    parameter int RO_IDX    = 23,
    parameter int ZERO_R0   = 0,
    localparam int AW       = $clog2(NUM_REGS),
    localparam int BEATS    = VTX_COUNT / VTX_LANES
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [RD_PORTS-1:0][AW-1:0]       rd_addr,
    output logic [RD_PORTS-1:0][DATA_W-1:0]   rd_data,
    output logic [RD_PORTS-1:0]               rd_busy,
    input  logic [WR_PORTS-1:0]               wr_en,
    input  logic [WR_PORTS-1:0][AW-1:0]       wr_addr,
    input  logic [WR_PORTS-1:0][DATA_W-1:0]   wr_data,
    input  logic                              flags_we,
    input  logic [DATA_W-1:0]                 flags_in,
    input  logic                              ro_we,
    input  logic [DATA_W-1:0]                 ro_in,
    input  logic                              vtx_hold,
    input  logic                              vtx_valid,
    output logic                              vtx_ready,
    input  logic [VTX_LANES-1:0][DATA_W-1:0]  vtx_data,
    output logic                              vtx_done,
    output logic [VTX_COUNT-1:0][DATA_W-1:0]  vtx_out,
    output logic                              wr_conflict,
    output logic [DATA_W-1:0]                 flags_out,
    output logic [DATA_W-1:0]                 ro_out
);

    if (VTX_COUNT % VTX_LANES != 0) begin : g_chk_lanes
        $error("VTX_COUNT must be a multiple of VTX_LANES");
    end
    if (VTX_BASE + VTX_COUNT > NUM_REGS) begin : g_chk_range
        $error("vertex window exceeds NUM_REGS");
    end
    if (in_vtx(FLAG_IDX, VTX_BASE, VTX_COUNT) || in_vtx(RO_IDX, VTX_BASE, VTX_COUNT) || FLAG_IDX == RO_IDX) begin : g_chk_idx
        $error("FLAG_IDX/RO_IDX must be distinct and outside the vertex window");
    end

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic                conflict_q, conflict_d;
    logic                busy;
    logic [BEATS-1:0]    grp_we;
    logic [NUM_REGS-1:0] vpu_wr;
    logic [WR_PORTS-1:0] cpu_ok;

    vtx_burst_ctrl #(.BEATS(BEATS)) u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .vtx_hold  (vtx_hold),
        .vtx_valid (vtx_valid),
        .vtx_ready (vtx_ready),
        .vtx_done  (vtx_done),
        .busy      (busy),
        .grp_we    (grp_we)
    );

    // per-register "VPU writes this register this cycle"
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_vw
        if (r >= VTX_BASE && r < VTX_BASE + VTX_COUNT) begin : g_v
            assign vpu_wr[r] = grp_we[(r - VTX_BASE) / VTX_LANES];
        end else begin : g_n
            assign vpu_wr[r] = 1'b0;
        end
    end

    for (genvar i = 0; i < VTX_COUNT; i++) begin : g_vo
        assign vtx_out[i] = regs_q[VTX_BASE + i];
    end

    assign flags_out   = regs_q[FLAG_IDX];
    assign ro_out      = regs_q[RO_IDX];
    assign wr_conflict = conflict_q;

    // CPU port qualification and conflict detection; RO_IDX writes vanish silently
    always_comb begin
        conflict_d = 1'b0;
        for (int p = 0; p < WR_PORTS; p++) begin
            cpu_ok[p] = 1'b0;
            if (wr_en[p] && wr_addr[p] != AW'(RO_IDX)) begin
                if (in_vtx(int'(wr_addr[p]), VTX_BASE, VTX_COUNT) && (busy || vpu_wr[wr_addr[p]])) begin
                    conflict_d = 1'b1;
                end else begin
                    cpu_ok[p] = !(ZERO_R0 != 0 && wr_addr[p] == '0);
                end
                if (flags_we && wr_addr[p] == AW'(FLAG_IDX)) begin
                    conflict_d = 1'b1;
                end
                for (int q = p + 1; q < WR_PORTS; q++) begin
                    if (wr_en[q] && wr_addr[q] == wr_addr[p]) begin
                        conflict_d = 1'b1;
                    end
                end
            end
        end
    end

    // later assignments win: higher CPU port, then flags, then return object, then VPU
    always_comb begin
        regs_d = regs_q;
        for (int p = 0; p < WR_PORTS; p++) begin
            if (cpu_ok[p]) begin
                regs_d[wr_addr[p]] = wr_data[p];
            end
        end
        if (flags_we) begin
            regs_d[FLAG_IDX] = flags_in;
        end
        if (ro_we) begin
            regs_d[RO_IDX] = ro_in;
        end
        for (int g = 0; g < BEATS; g++) begin
            for (int l = 0; l < VTX_LANES; l++) begin
                if (grp_we[g]) begin
                    regs_d[VTX_BASE + g * VTX_LANES + l] = vtx_data[l];
                end
            end
        end
    end

    // write-first read: only CPU and flags writes are forwarded, VPU beats are not
    always_comb begin
        for (int p = 0; p < RD_PORTS; p++) begin
            rd_data[p] = regs_q[rd_addr[p]];
            for (int q = 0; q < WR_PORTS; q++) begin
                if (cpu_ok[q] && wr_addr[q] == rd_addr[p]) begin
                    rd_data[p] = wr_data[q];
                end
            end
            if (flags_we && rd_addr[p] == AW'(FLAG_IDX)) begin
                rd_data[p] = flags_in;
            end
            if (ZERO_R0 != 0 && rd_addr[p] == '0) begin
                rd_data[p] = '0;
            end
            rd_busy[p] = busy && in_vtx(int'(rd_addr[p]), VTX_BASE, VTX_COUNT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
            conflict_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            conflict_q <= conflict_d;
        end
    end

endmodule
